tcam_lookup_controller: RTL and testbench

//  Shares one ternary CAM between two requesters (A, B) with round-robin arbitration.

---
 rtl/tcam_ctrl_pkg.sv | 18 +
 rtl/tcam_priority_encoder.sv | 25 ++
 rtl/tcam_lookup_controller.sv | 132 +++++++++++++
 tb/tb_tcam_lookup_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_ctrl_pkg.sv
// Shared types for the TCAM lookup controller.
// Optional feature macro: TCAM_CTRL_MATCH_COUNT_EN (adds rsp_count).
package tcam_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OP_SEARCH = 1'b0;
    localparam logic OP_WRITE  = 1'b1;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/tcam_priority_encoder.sv
// Lowest-index-wins encoder for the CAM match vector.
// Purely combinational; all-zero vector gives hit 0, index 0.
module tcam_priority_encoder
    import tcam_ctrl_pkg::*;
#(
    parameter int ADDRESS_SIZE = 4,
    localparam int ENTRIES = 1 << ADDRESS_SIZE
) (
    input  logic [ENTRIES-1:0]      vec,
    output logic                    hit,
    output logic [ADDRESS_SIZE-1:0] index
);

    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                hit   = 1'b1;
                index = i[ADDRESS_SIZE-1:0];
            end
        end
    end

endmodule

// File: rtl/tcam_lookup_controller.sv
// Round-robin front end sharing one TCAM between requesters A and B.
// Define TCAM_CTRL_MATCH_COUNT_EN to add the rsp_count popcount output.
module tcam_lookup_controller
    import tcam_ctrl_pkg::*;
#(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 4,
    localparam int ENTRIES = 1 << ADDRESS_SIZE
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic                    a_op,
    input  logic [WORD_SIZE-1:0]    a_word,
    input  logic [WORD_SIZE-1:0]    a_mask,
    input  logic [ADDRESS_SIZE-1:0] a_addr,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic                    b_op,
    input  logic [WORD_SIZE-1:0]    b_word,
    input  logic [WORD_SIZE-1:0]    b_mask,
    input  logic [ADDRESS_SIZE-1:0] b_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic                    rsp_hit,
    output logic [ADDRESS_SIZE-1:0] rsp_index,
`ifdef TCAM_CTRL_MATCH_COUNT_EN
    output logic [ADDRESS_SIZE:0]   rsp_count,
`endif
    output logic [WORD_SIZE-1:0]    tcam_word,
    output logic [WORD_SIZE-1:0]    tcam_mask,
    output logic [ADDRESS_SIZE-1:0] tcam_address,
    output logic                    tcam_write,
    input  logic [ENTRIES-1:0]      tcam_matched
);

    state_t state, state_n;

    logic               last_grant;
    logic               op_q;
    logic               id_q;
    logic [ENTRIES-1:0] match_q;
    logic               grant_a;
    logic               grant_b;
    logic               accept;

    // Contention goes to whoever was not served last.
    always_comb begin
        grant_a = a_valid & (~b_valid | (last_grant == REQ_B));
        grant_b = b_valid & (~a_valid | (last_grant == REQ_A));
    end

    assign a_ready   = (state == IDLE) & grant_a;
    assign b_ready   = (state == IDLE) & grant_b;
    assign accept    = a_ready | b_ready;
    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The CAM pins double as the request latch for word/mask/addr.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant   <= REQ_B;
            op_q         <= OP_SEARCH;
            id_q         <= REQ_A;
            match_q      <= '0;
            tcam_word    <= '0;
            tcam_mask    <= '0;
            tcam_address <= '0;
            tcam_write   <= 1'b0;
        end else begin
            tcam_write <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        id_q         <= b_ready ? REQ_B : REQ_A;
                        op_q         <= b_ready ? b_op : a_op;
                        tcam_word    <= b_ready ? b_word : a_word;
                        tcam_mask    <= b_ready ? b_mask : a_mask;
                        tcam_address <= b_ready ? b_addr : a_addr;
                        tcam_write   <= b_ready ? b_op : a_op;
                    end
                end
                WAIT: begin
                    match_q <= (op_q == OP_SEARCH) ? tcam_matched : '0;
                end
                RESP: begin
                    if (rsp_ready) last_grant <= id_q;
                end
                default: ;
            endcase
        end
    end

    tcam_priority_encoder #(
        .ADDRESS_SIZE(ADDRESS_SIZE)
    ) u_penc (
        .vec  (match_q),
        .hit  (rsp_hit),
        .index(rsp_index)
    );

`ifdef TCAM_CTRL_MATCH_COUNT_EN
    always_comb begin
        rsp_count = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            rsp_count = rsp_count + {{ADDRESS_SIZE{1'b0}}, match_q[i]};
        end
    end
`endif

endmodule

// File: tb/tb_tcam_lookup_controller.sv
// Scoreboard bench for tcam_lookup_controller with a behavioural TCAM.
// Honours TCAM_CTRL_MATCH_COUNT_EN for the rsp_count port.
module tb_tcam_lookup_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic        a_op = 1'b0, b_op = 1'b0;
    logic [7:0]  a_word = '0, a_mask = '0, b_word = '0, b_mask = '0;
    logic [3:0]  a_addr = '0, b_addr = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_hit;
    logic [3:0]  rsp_index;
    logic [4:0]  rsp_count;
    logic [7:0]  tcam_word, tcam_mask;
    logic [3:0]  tcam_address;
    logic        tcam_write;
    logic [15:0] tcam_matched = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tcam_lookup_controller #(.WORD_SIZE(8), .ADDRESS_SIZE(4)) dut (
        .clock(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op),
        .a_word(a_word), .a_mask(a_mask), .a_addr(a_addr),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op),
        .b_word(b_word), .b_mask(b_mask), .b_addr(b_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_hit(rsp_hit), .rsp_index(rsp_index),
`ifdef TCAM_CTRL_MATCH_COUNT_EN
        .rsp_count(rsp_count),
`endif
        .tcam_word(tcam_word), .tcam_mask(tcam_mask),
        .tcam_address(tcam_address), .tcam_write(tcam_write),
        .tcam_matched(tcam_matched)
    );

`ifndef TCAM_CTRL_MATCH_COUNT_EN
    assign rsp_count = '0;
`endif

    // Behavioural TCAM: one-clock registered match output.
    logic [7:0] cam_w [16];
    bit         cam_v [16];
    always @(posedge clk) begin : cam
        logic [15:0] m;
        for (int i = 0; i < 16; i++)
            m[i] = cam_v[i] && (((cam_w[i] ^ tcam_word) & ~tcam_mask) == 8'h00);
        tcam_matched <= m;
        if (tcam_write) begin
            cam_w[tcam_address] <= tcam_word;
            cam_v[tcam_address] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit       id;
        bit       hit;
        bit [3:0] idx;
        bit [4:0] cnt;
    } exp_t;

    exp_t sb[$];
    bit   acc_log[$];
    bit   ref_v [16];
    bit [7:0] ref_w [16];
    int   last_acc = 0;
    bit   seen = 0;

    function automatic void push(bit id, bit op, bit [7:0] w, bit [7:0] m, bit [3:0] ad);
        exp_t e;
        e.id = id; e.hit = 0; e.idx = 0; e.cnt = 0;
        if (op) begin
            ref_w[ad] = w;
            ref_v[ad] = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (ref_v[i] && (((ref_w[i] ^ w) & ~m) == 8'h00)) begin
                    e.cnt++;
                    if (!e.hit) begin
                        e.hit = 1;
                        e.idx = 4'(i);
                    end
                end
            end
        end
        sb.push_back(e);
        acc_log.push_back(id);
        last_acc = cyc;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (a_valid && a_ready)
                push(0, a_op, a_word, a_mask, a_addr);
            else if (b_valid && b_ready)
                push(1, b_op, b_word, b_mask, b_addr);
            if (tcam_write)
                chk("write_strobe_cycle", cyc - last_acc, 1);
            if (rsp_valid && sb.size() == 0)
                chk("spurious_rsp", 1, 0);
            if (rsp_valid && sb.size() > 0 && !seen) begin
                chk("rsp_latency", cyc - last_acc, 3);
                seen = 1;
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                seen = 0;
                chk("rsp_id", int'(rsp_id), int'(e.id));
                chk("rsp_hit", int'(rsp_hit), int'(e.hit));
                chk("rsp_index", int'(rsp_index), int'(e.idx));
`ifdef TCAM_CTRL_MATCH_COUNT_EN
                chk("rsp_count", int'(rsp_count), int'(e.cnt));
`endif
            end
        end
    end

    task automatic send(input bit who, input bit op, input bit [7:0] w,
                        input bit [7:0] m, input bit [3:0] ad);
        bit ok;
        @(posedge clk); #1;
        if (who) begin
            b_op = op; b_word = w; b_mask = m; b_addr = ad; b_valid = 1;
        end else begin
            a_op = op; a_word = w; a_mask = m; a_addr = ad; a_valid = 1;
        end
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((who ? b_ready : a_ready) == 1'b1) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        if (who) b_valid = 0; else a_valid = 0;
        if (!ok) chk("grant_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1;
        sb.delete();
        acc_log.delete();
        seen = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_tcam_write", int'(tcam_write), 0);
        chk("reset_tcam_word", int'(tcam_word), 0);
        chk("reset_rsp_hit", int'(rsp_hit), 0);
        chk("reset_a_ready", int'(a_ready), 0);
        @(posedge clk); #1;
        reset = 1;

        // write then exact search
        send(0, 1, 8'hA5, 8'h00, 4'd3);
        drain();
        send(0, 0, 8'hA5, 8'h00, 4'd0);
        drain();

        // masked search hitting two entries
        send(0, 1, 8'h10, 8'h00, 4'd2);
        send(1, 1, 8'h1F, 8'h00, 4'd5);
        drain();
        send(1, 0, 8'h10, 8'h0F, 4'd0);
        drain();

        // both requesters busy: alternation from reset
        do_reset();
        fork
            begin
                send(0, 0, 8'hA5, 8'h00, 4'd0);
                send(0, 0, 8'h1F, 8'h00, 4'd0);
            end
            begin
                send(1, 0, 8'h10, 8'hF0, 4'd0);
                send(1, 0, 8'h33, 8'h00, 4'd0);
            end
        join
        drain();
        chk("grant_count", acc_log.size(), 4);
        for (int i = 0; i < acc_log.size() && i < 4; i++)
            chk($sformatf("grant_order_%0d", i), int'(acc_log[i]), i % 2);

        // miss with backpressure
        rsp_ready = 0;
        send(0, 0, 8'hFF, 8'h00, 4'd0);
        begin
            bit up;
            up = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    up = 1;
                    break;
                end
            end
            if (!up) chk("rsp_timeout", 0, 1);
        end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("rsp_held", int'(rsp_valid), 1);
        end
        @(posedge clk); #1;
        rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rsp_retired", int'(rsp_valid), 0);
        drain();

        // reset while a search sits in WAIT
        send(0, 0, 8'hA5, 8'h00, 4'd0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        @(negedge clk);
        chk("midreset_rsp_valid", int'(rsp_valid), 0);
        chk("midreset_tcam_write", int'(tcam_write), 0);
        @(posedge clk); #1;
        reset = 1;
        sb.delete();
        acc_log.delete();
        seen = 0;
        @(negedge clk);
        chk("post_reset_rsp_valid", int'(rsp_valid), 0);
        chk("post_reset_tcam_write", int'(tcam_write), 0);
        send(0, 0, 8'h1F, 8'h00, 4'd0);
        drain();
        chk("post_reset_grant", acc_log.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
